// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire trace buffer: FSM states, capture-mode codes,
// default geometry and the packed trace-entry layout.
package retire_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_ALL     = 2'b00;
  localparam logic [1:0] MODE_REGW    = 2'b01;
  localparam logic [1:0] MODE_CTRL    = 2'b10;
  localparam logic [1:0] MODE_ALL_ALT = 2'b11;

  localparam int FLAGS_W    = 3;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_POST_W = 8;

  // Entry layout, MSB first: {pc, instruction, wr_data, wr_reg, reg_write, branch, jump}
  function automatic int entry_width(input int addr_w, input int data_w, input int reg_aw);
    return addr_w + 2 * data_w + reg_aw + FLAGS_W;
  endfunction

  function automatic logic mode_match(input logic [1:0] mode, input logic reg_write,
                                      input logic branch, input logic jump);
    logic m;
    m = 1'b1;
    case (mode)
      MODE_ALL:     m = 1'b1;
      MODE_REGW:    m = reg_write;
      MODE_CTRL:    m = branch | jump;
      MODE_ALL_ALT: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Bundle of retire, configuration, status, drain and mirror-read signals of the trace buffer.
// The master side is the core/debugger, the slave side is the trace buffer.
interface retire_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int POST_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              retire_valid;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              reg_write;
  logic [REG_AW-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              branch;
  logic              jump;
  logic [1:0]        cfg_mode;
  logic              arm;
  logic [ADDR_W-1:0] trig_pc;
  logic [POST_W-1:0] post_count;
  logic [1:0]        state;
  logic              triggered;
  logic              overflow;
  logic [CNT_W-1:0]  count;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic [DATA_W-1:0] rd_wdata;
  logic [REG_AW-1:0] rd_wreg;
  logic [2:0]        rd_flags;
  logic [REG_AW-1:0] shadow_addr;
  logic [DATA_W-1:0] shadow_data;

  modport master (
    output retire_valid, pc, instruction, reg_write, wr_reg, wr_data, branch, jump,
           cfg_mode, arm, trig_pc, post_count, rd_ready, shadow_addr,
    input  state, triggered, overflow, count, rd_valid, rd_pc, rd_instr, rd_wdata,
           rd_wreg, rd_flags, shadow_data
  );

  modport slave (
    input  retire_valid, pc, instruction, reg_write, wr_reg, wr_data, branch, jump,
           cfg_mode, arm, trig_pc, post_count, rd_ready, shadow_addr,
    output state, triggered, overflow, count, rd_valid, rd_pc, rd_instr, rd_wdata,
           rd_wreg, rd_flags, shadow_data
  );
endinterface

// File: rtl/retire_trace_buffer_ring.sv
// Circular trace storage: push overwrites the oldest entry when full (sticky overflow),
// pop retires the oldest entry; clear empties the ring and drops the overflow flag.
module retire_trace_buffer_ring #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 104
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [ENTRY_W-1:0]     push_entry_i,
  output logic [ENTRY_W-1:0]     rd_entry_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full;

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (full) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_i && count_q != '0) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign rd_entry_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-trace capture unit: register-file mirror, capture FSM with mode filter,
// PC trigger and post-trigger count, feeding a circular buffer drained via valid/ready.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int POST_W = DEF_POST_W
) (
  input logic                  clk,
  input logic                  rst,
  retire_trace_buffer_if.slave bus
);
  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W, REG_AW);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int NREG    = 2 ** REG_AW;

  trace_state_e      state_q, state_d;
  logic [POST_W-1:0] post_q, post_d;
  logic              trig_q, trig_d;
  logic              push, pop, clear;
  logic              qualify, hit, mirror_we, rd_valid;
  logic [ENTRY_W-1:0] push_entry, rd_entry;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DATA_W-1:0] mirror_q [NREG];

  assign qualify    = bus.retire_valid && mode_match(bus.cfg_mode, bus.reg_write, bus.branch, bus.jump);
  assign hit        = bus.retire_valid && (bus.pc == bus.trig_pc);
  assign push_entry = {bus.pc, bus.instruction, bus.wr_data, bus.wr_reg,
                       bus.reg_write, bus.branch, bus.jump};
  assign rd_valid   = (state_q == ST_DONE) && (count != '0);

  // arm takes priority over any capture or pop in the same cycle
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    trig_d  = trig_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (bus.arm) begin
      clear   = 1'b1;
      trig_d  = 1'b0;
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (hit) begin
            push    = 1'b1;
            trig_d  = 1'b1;
            post_d  = bus.post_count;
            state_d = (bus.post_count == '0) ? ST_DONE : ST_POST;
          end else if (qualify) begin
            push = 1'b1;
          end
        end
        ST_POST: begin
          if (qualify) begin
            push   = 1'b1;
            post_d = post_q - POST_W'(1);
            if (post_q == POST_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: pop = rd_valid && bus.rd_ready;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      post_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
    end
  end

  // Register mirror tracks write-back in every state and is never cleared by arm
  assign mirror_we = bus.retire_valid && bus.reg_write && (bus.wr_reg != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mirror_q[i] <= '0;
    end else if (mirror_we) begin
      mirror_q[bus.wr_reg] <= bus.wr_data;
    end
  end

  retire_trace_buffer_ring #(
    .DEPTH  (DEPTH),
    .ENTRY_W(ENTRY_W)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .push_i      (push),
    .pop_i       (pop),
    .push_entry_i(push_entry),
    .rd_entry_o  (rd_entry),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  assign bus.state       = state_q;
  assign bus.triggered   = trig_q;
  assign bus.overflow    = overflow;
  assign bus.count       = count;
  assign bus.rd_valid    = rd_valid;
  assign {bus.rd_pc, bus.rd_instr, bus.rd_wdata, bus.rd_wreg, bus.rd_flags} = rd_entry;
  assign bus.shadow_data = (bus.shadow_addr == '0) ? '0 : mirror_q[bus.shadow_addr];
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the capture rules.
module tb_retire_trace_buffer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 16;
  localparam int POST_W = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  retire_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
                           .DEPTH(DEPTH), .POST_W(POST_W)) bus ();

  retire_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
                        .DEPTH(DEPTH), .POST_W(POST_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [2:0]  flags;
  } ent_t;

  // Reference model: trace as a bounded queue, state as 0..3
  ent_t        m_q[$];
  int          m_state;
  bit          m_trig;
  bit          m_ovf;
  int          m_post;
  logic [31:0] m_mirror [32];

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    m_q.delete();
    m_state = 0;
    m_trig  = 1'b0;
    m_ovf   = 1'b0;
    m_post  = 0;
    for (int i = 0; i < 32; i++) m_mirror[i] = '0;
  endfunction

  function automatic void model_push(input ent_t e);
    if (m_q.size() == DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
    m_q.push_back(e);
  endfunction

  function automatic void model_clock();
    ent_t e;
    bit   qual, hit;
    if (bus.retire_valid && bus.reg_write && bus.wr_reg != 0) m_mirror[bus.wr_reg] = bus.wr_data;
    e.pc    = bus.pc;
    e.instr = bus.instruction;
    e.wdata = bus.wr_data;
    e.wreg  = bus.wr_reg;
    e.flags = {bus.reg_write, bus.branch, bus.jump};
    case (bus.cfg_mode)
      2'b01:   qual = bus.reg_write;
      2'b10:   qual = bus.branch || bus.jump;
      default: qual = 1'b1;
    endcase
    qual = qual && bus.retire_valid;
    hit  = bus.retire_valid && (bus.pc == bus.trig_pc);
    if (bus.arm) begin
      m_q.delete();
      m_trig  = 1'b0;
      m_ovf   = 1'b0;
      m_state = 1;
      return;
    end
    if (m_state == 1) begin
      if (hit) begin
        model_push(e);
        m_trig  = 1'b1;
        m_post  = int'(bus.post_count);
        m_state = (m_post == 0) ? 3 : 2;
      end else if (qual) begin
        model_push(e);
      end
    end else if (m_state == 2) begin
      if (qual) begin
        model_push(e);
        m_post = m_post - 1;
        if (m_post == 0) m_state = 3;
      end
    end else if (m_state == 3) begin
      if (m_q.size() != 0 && bus.rd_ready) void'(m_q.pop_front());
    end
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic [31:0] pc, input logic rw, input logic [4:0] wreg,
                            input logic [31:0] wdata, input logic br, input logic jp);
    bus.retire_valid = 1'b1;
    bus.pc           = pc;
    bus.instruction  = 32'h1000_0000 ^ pc;
    bus.reg_write    = rw;
    bus.wr_reg       = wreg;
    bus.wr_data      = wdata;
    bus.branch       = br;
    bus.jump         = jp;
  endtask

  task automatic clear_retire();
    bus.retire_valid = 1'b0;
    bus.reg_write    = 1'b0;
    bus.branch       = 1'b0;
    bus.jump         = 1'b0;
  endtask

  task automatic arm_cfg(input logic [1:0] mode, input logic [31:0] tpc, input logic [7:0] post);
    bus.cfg_mode   = mode;
    bus.trig_pc    = tpc;
    bus.post_count = post;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic apply_reset();
    clear_retire();
    bus.arm      = 1'b0;
    bus.rd_ready = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.triggered !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b t=%b o=%b want 0 0 0", bus.rd_valid, bus.triggered, bus.overflow);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_capture();
    arm_cfg(2'b00, 32'hFFFF_FFF0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      set_retire(32'(4 * k), 1'b1, 5'(k), 32'hA500_0000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    clear_retire();
    checks++; if (bus.count !== CNT_W'(3)) begin errors++; $display("FAIL midcap_count got %0d want 3", bus.count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL midcap_state got %0d want 0", bus.state); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL midcap_count0 got %0d want 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midcap_rd_valid got %b want 0", bus.rd_valid); end
    for (int i = 0; i < 32; i++) begin
      bus.shadow_addr = 5'(i);
      #1;
      checks++;
      if (bus.shadow_data !== 32'h0) begin
        errors++; $display("FAIL midcap_shadow[%0d] got %h want 0", i, bus.shadow_data);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("test_reset_mid_capture done");
  endtask

  task automatic test_mode_regw();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h4, 32'hC, 32'h10, 32'h14, 32'h18};
    arm_cfg(2'b01, 32'h10, 8'd2);
    for (int k = 0; k <= 8; k++) begin
      logic [31:0] p;
      logic        rw;
      p  = 32'(4 * k);
      rw = (p == 32'h4 || p == 32'hC || p == 32'h14 || p == 32'h18);
      set_retire(p, rw, 5'(k + 1), p * 3, 1'b0, 1'b0);
      tick();
      if (p == 32'h14) begin
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL regw_post_state got %0d want 2", bus.state); end
      end
      if (p == 32'h18) begin
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL regw_done_state got %0d want 3", bus.state); end
      end
    end
    clear_retire();
    checks++; if (bus.count !== CNT_W'(5)) begin errors++; $display("FAIL regw_count got %0d want 5", bus.count); end
    checks++; if (bus.triggered !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL regw_flags got t=%b o=%b want 1 0", bus.triggered, bus.overflow);
    end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc[i]) begin
        errors++; $display("FAIL regw_rd_pc[%0d] got v=%b pc=%h want 1 %h", i, bus.rd_valid, bus.rd_pc, exp_pc[i]);
      end
      $display("pop pc=%h", bus.rd_pc);
      tick();
    end
    bus.rd_ready = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0 || bus.count !== '0) begin
      errors++; $display("FAIL regw_drained got v=%b cnt=%0d want 0 0", bus.rd_valid, bus.count);
    end
    $display("test_mode_regw done");
  endtask

  task automatic test_overflow();
    arm_cfg(2'b00, 32'h4C, 8'd0);
    for (int k = 0; k < 20; k++) begin
      set_retire(32'(4 * k), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
      tick();
    end
    clear_retire();
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL ovf_state got %0d want 3", bus.state); end
    checks++; if (bus.count !== CNT_W'(16)) begin errors++; $display("FAIL ovf_count got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    checks++; if (bus.rd_pc !== 32'h10) begin errors++; $display("FAIL ovf_first_pc got %h want 00000010", bus.rd_pc); end
    $display("test_overflow done");
  endtask

  task automatic test_backpressure();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rd_pc !== 32'h10 || bus.count !== CNT_W'(16) || bus.rd_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold got pc=%h cnt=%0d v=%b want 00000010 16 1", bus.rd_pc, bus.count, bus.rd_valid);
      end
    end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.count !== CNT_W'(16 - i) || bus.rd_pc !== 32'(32'h10 + 4 * i)) begin
        errors++; $display("FAIL bp_drain[%0d] got cnt=%0d pc=%h want %0d %h", i, bus.count, bus.rd_pc, 16 - i, 32'h10 + 4 * i);
      end
      $display("pop pc=%h", bus.rd_pc);
      tick();
    end
    bus.rd_ready = 1'b0;
    checks++; if (bus.count !== '0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got cnt=%0d v=%b want 0 0", bus.count, bus.rd_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_mirror();
    apply_reset();
    set_retire(32'h40, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    set_retire(32'h44, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
    tick();
    clear_retire();
    checks++; if (bus.state !== 2'd0 || bus.count !== '0) begin
      errors++; $display("FAIL mirror_idle got st=%0d cnt=%0d want 0 0", bus.state, bus.count);
    end
    bus.shadow_addr = 5'd8;
    #1;
    checks++; if (bus.shadow_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mirror_r8 got %h want deadbeef", bus.shadow_data); end
    bus.shadow_addr = 5'd0;
    #1;
    checks++; if (bus.shadow_data !== 32'h0) begin errors++; $display("FAIL mirror_r0 got %h want 0", bus.shadow_data); end
    arm_cfg(2'b00, 32'h0, 8'd1);
    bus.shadow_addr = 5'd8;
    #1;
    checks++; if (bus.shadow_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mirror_arm got %h want deadbeef", bus.shadow_data); end
    $display("test_mirror done");
  endtask

  task automatic test_rearm();
    arm_cfg(2'b00, 32'h100, 8'd5);
    for (int k = 0; k < 17; k++) begin
      set_retire(32'(32'h200 + 4 * k), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    set_retire(32'h100, 1'b1, 5'd3, 32'h55, 1'b0, 1'b0);
    tick();
    checks++; if (bus.state !== 2'd2 || bus.triggered !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL rearm_pre got st=%0d t=%b o=%b want 2 1 1", bus.state, bus.triggered, bus.overflow);
    end
    set_retire(32'h300, 1'b1, 5'd4, 32'h66, 1'b1, 1'b1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    clear_retire();
    checks++; if (bus.state !== 2'd1 || bus.count !== '0) begin
      errors++; $display("FAIL rearm_state got st=%0d cnt=%0d want 1 0", bus.state, bus.count);
    end
    checks++; if (bus.triggered !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL rearm_flags got t=%b o=%b want 0 0", bus.triggered, bus.overflow);
    end
    $display("test_rearm done");
  endtask

  task automatic test_random();
    logic [31:0] exp_sh;
    bit          exp_v;
    arm_cfg(2'($urandom_range(0, 3)), 32'(4 * $urandom_range(0, 15)), 8'($urandom_range(0, 6)));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.retire_valid = ($urandom_range(0, 9) < 7);
      bus.pc           = 32'(4 * $urandom_range(0, 15));
      bus.instruction  = $urandom;
      bus.reg_write    = 1'($urandom_range(0, 1));
      bus.wr_reg       = 5'($urandom_range(0, 31));
      bus.wr_data      = $urandom;
      bus.branch       = ($urandom_range(0, 3) == 0);
      bus.jump         = ($urandom_range(0, 5) == 0);
      bus.rd_ready     = 1'($urandom_range(0, 1));
      bus.shadow_addr  = 5'($urandom_range(0, 31));
      bus.arm          = ($urandom_range(0, 49) == 0);
      if (bus.arm) begin
        bus.cfg_mode   = 2'($urandom_range(0, 3));
        bus.trig_pc    = 32'(4 * $urandom_range(0, 15));
        bus.post_count = 8'($urandom_range(0, 6));
      end
      tick();
      exp_v  = (m_state == 3) && (m_q.size() != 0);
      exp_sh = (bus.shadow_addr == 5'd0) ? 32'h0 : m_mirror[bus.shadow_addr];
      checks++; if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", cyc, bus.state, m_state); end
      checks++; if (bus.count !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, bus.count, m_q.size()); end
      checks++; if (bus.triggered !== m_trig || bus.overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_flags cyc %0d got t=%b o=%b want %b %b", cyc, bus.triggered, bus.overflow, m_trig, m_ovf);
      end
      checks++; if (bus.rd_valid !== exp_v) begin errors++; $display("FAIL rnd_rd_valid cyc %0d got %b want %b", cyc, bus.rd_valid, exp_v); end
      checks++; if (bus.shadow_data !== exp_sh) begin errors++; $display("FAIL rnd_shadow cyc %0d got %h want %h", cyc, bus.shadow_data, exp_sh); end
      if (m_q.size() != 0) begin
        checks++;
        if (bus.rd_pc !== m_q[0].pc || bus.rd_instr !== m_q[0].instr || bus.rd_wdata !== m_q[0].wdata ||
            bus.rd_wreg !== m_q[0].wreg || bus.rd_flags !== m_q[0].flags) begin
          errors++;
          $display("FAIL rnd_entry cyc %0d got pc=%h in=%h wd=%h wr=%0d fl=%b want %h %h %h %0d %b", cyc,
                   bus.rd_pc, bus.rd_instr, bus.rd_wdata, bus.rd_wreg, bus.rd_flags,
                   m_q[0].pc, m_q[0].instr, m_q[0].wdata, m_q[0].wreg, m_q[0].flags);
        end
      end
    end
    bus.arm = 1'b0;
    clear_retire();
    bus.rd_ready = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    bus.retire_valid = 1'b0;
    bus.pc           = '0;
    bus.instruction  = '0;
    bus.reg_write    = 1'b0;
    bus.wr_reg       = '0;
    bus.wr_data      = '0;
    bus.branch       = 1'b0;
    bus.jump         = 1'b0;
    bus.cfg_mode     = 2'b00;
    bus.arm          = 1'b0;
    bus.trig_pc      = '0;
    bus.post_count   = '0;
    bus.rd_ready     = 1'b0;
    bus.shadow_addr  = '0;
    model_reset();
    test_reset();
    test_reset_mid_capture();
    test_mode_regw();
    test_overflow();
    test_backpressure();
    test_mirror();
    test_rearm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
